wdt_kick_unlock: RTL and testbench
==================================

Name: wdt_kick_unlock

Overview:
- Upstream qualifier for the watchdog timer. Turns raw software kick writes into the watchdog's one-cycle clear pulse.
- A clear is generated only after a two-byte unlock sequence (KEY1 then KEY2) that arrives no earlier than a minimum window after the previous clear.
- Malformed, late or premature sequences produce no clear and flag an error, so a runaway CPU cannot keep the watchdog alive by accident.

Parameters:
- KEY1, 8'h55: first unlock byte.
- KEY2, 8'hAA: second unlock byte.
- KEY_GAP, 8: maximum cycles allowed from the KEY1 write to the KEY2 write.
- MIN_WINDOW, 4: minimum cycles since the last clear (or reset) before a KEY2 write is accepted.
- CNT_W, 16: width of the window counter and the kick counter.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_wr_en  input  1  one-cycle kick-write strobe from the bus.
- i_wr_data  input  8  kick byte, valid when i_wr_en=1.
- o_clrwdt  output  1  one-cycle clear pulse; drives the watchdog's i_clrwdt.
- o_key_err  output  1  one-cycle pulse: wrong byte, or KEY_GAP timeout.
- o_early_err  output  1  one-cycle pulse: correct sequence inside MIN_WINDOW.
- o_armed  output  1  high while in state GOT_KEY1.
- o_kick_cnt  output  CNT_W  count of accepted clears; saturates at all-ones.

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rst is asynchronous, active-high.
- Reset values:
  - o_clrwdt=0, o_key_err=0, o_early_err=0, o_armed=0, o_kick_cnt=0.
  - State=IDLE, gap counter=0.
  - Window counter=0; reset counts as a clear.
- Window counter:
  - Increments every cycle and saturates at all-ones.
  - Cleared to 0 in the cycle o_clrwdt is asserted.
- State IDLE:
  - i_wr_en with data==KEY1 -> GOT_KEY1; gap counter=0.
  - i_wr_en with any other data -> o_key_err pulse; stay IDLE.
- State GOT_KEY1:
  - Gap counter increments each cycle without a write.
  - Gap counter reaches KEY_GAP with no write -> o_key_err; go to IDLE.
  - i_wr_en with data==KEY2 and window>=MIN_WINDOW -> o_clrwdt; o_kick_cnt+1; go to IDLE.
  - i_wr_en with data==KEY2 and window<MIN_WINDOW -> o_early_err; go to IDLE.
  - i_wr_en with any other data, including KEY1 -> o_key_err; go to IDLE. A repeated KEY1 does not re-arm.
- Window compare: uses the counter value in the cycle the KEY2 write is sampled.
- Latency: all pulse outputs are registered and appear the cycle after the triggering write is sampled. Pulses never exceed one cycle.
- Mutual exclusion: at most one of o_clrwdt, o_key_err, o_early_err is high in any cycle.
- Gap timeout vs write: if the timeout and a write fall on the same cycle, the write wins and is evaluated normally.
- o_armed: combinational decode of state==GOT_KEY1.
- Reset mid-sequence: returns to IDLE immediately, with no pulse on deassertion.
- i_wr_data: ignored when i_wr_en=0.

Optional Feature:
- Macro: WDT_KICK_ERR_FORCE_EN
- Defined:
  - Adds output o_force_fail (1 bit), reset 0.
  - Set by any o_key_err or o_early_err pulse and held until i_rst.
  - While set, further valid sequences are evaluated, but o_clrwdt is suppressed and o_kick_cnt is frozen. A single error therefore guarantees the watchdog will expire.
- Undefined: no o_force_fail port; errors are pulses only and later valid sequences clear normally.

Decomposition:
- Shared package wdt_pkg:
  - State encoding localparams: IDLE=1'b0, GOT_KEY1=1'b1.
  - Default KEY1/KEY2 constants.
  - CNT_W default, also used by the watchdog's period inputs.
- One natural sub-module, wdt_sat_counter: a width-parameterised saturating up-counter with synchronous clear. Instantiated for the window counter and the kick counter.
- The gap counter stays inline.

Test Plan:
- Reset, then idle 10 cycles, then write 55 and AA on consecutive cycles -> o_clrwdt high exactly one cycle, 1 cycle after the AA write; o_kick_cnt=1.
- Clear once, then write 55 at +1 cycle and AA at +2 cycles (window 2<4) -> o_early_err pulse, no o_clrwdt, o_kick_cnt unchanged.
- Write 55, then wait 9 cycles -> o_key_err pulse after 8 cycles; o_armed falls; a following lone AA -> another o_key_err.
- Write 55, 55, AA -> o_key_err on the second 55; the AA seen in IDLE -> o_key_err; no clear.
- Assert i_rst one cycle after 55 -> o_armed=0 immediately, no pulses; a subsequent 55/AA with window>=4 -> clear.
- With WDT_KICK_ERR_FORCE_EN: write 12 -> o_force_fail=1; a later valid 55/AA -> no o_clrwdt; o_force_fail stays high until i_rst.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog block: kick-unlock state encoding,
// default unlock keys and the common counter width.
package wdt_pkg;

    localparam int         CNT_W_DEF = 16;
    localparam logic [7:0] KEY1_DEF  = 8'h55;
    localparam logic [7:0] KEY2_DEF  = 8'hAA;

    typedef enum logic {
        IDLE     = 1'b0,
        GOT_KEY1 = 1'b1
    } kick_state_e;

endpackage

// File: rtl/wdt_sat_counter.sv
// Width-parameterised saturating up-counter with synchronous clear.
// Clear has priority over increment; the count sticks at all-ones.
module wdt_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/wdt_kick_unlock.sv
// Qualifies software kick writes (KEY1 then KEY2) into a one-cycle watchdog clear.
// Optional sticky failure mode: define WDT_KICK_ERR_FORCE_EN.
module wdt_kick_unlock
    import wdt_pkg::*;
#(
    parameter logic [7:0] KEY1       = KEY1_DEF,
    parameter logic [7:0] KEY2       = KEY2_DEF,
    parameter int         KEY_GAP    = 8,
    parameter int         MIN_WINDOW = 4,
    parameter int         CNT_W      = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [7:0]       i_wr_data,
    output logic             o_clrwdt,
    output logic             o_key_err,
    output logic             o_early_err,
    output logic             o_armed,
    output logic [CNT_W-1:0] o_kick_cnt
`ifdef WDT_KICK_ERR_FORCE_EN
    ,
    output logic             o_force_fail
`endif
);

    localparam int GAP_W = $clog2(KEY_GAP + 1);

    kick_state_e      state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             clr_q, clr_d;
    logic             kerr_q, kerr_d;
    logic             eerr_q, eerr_d;
    logic             seq_ok;
    logic             force_q;
    logic [CNT_W-1:0] win_cnt;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        seq_ok  = 1'b0;
        kerr_d  = 1'b0;
        eerr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_wr_en) begin
                    if (i_wr_data == KEY1) begin
                        state_d = GOT_KEY1;
                        gap_d   = '0;
                    end else begin
                        kerr_d = 1'b1;
                    end
                end
            end
            GOT_KEY1: begin
                // A write in the timeout cycle is still evaluated normally.
                if (i_wr_en) begin
                    state_d = IDLE;
                    if (i_wr_data == KEY2) begin
                        if (win_cnt >= CNT_W'(MIN_WINDOW)) begin
                            seq_ok = 1'b1;
                        end else begin
                            eerr_d = 1'b1;
                        end
                    end else begin
                        kerr_d = 1'b1;
                    end
                end else if (gap_q == GAP_W'(KEY_GAP - 1)) begin
                    state_d = IDLE;
                    kerr_d  = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef WDT_KICK_ERR_FORCE_EN
    // Once any error is seen, valid sequences no longer reach the watchdog.
    assign clr_d = seq_ok & ~force_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            force_q <= 1'b0;
        end else if (kerr_d || eerr_d) begin
            force_q <= 1'b1;
        end
    end

    assign o_force_fail = force_q;
`else
    assign clr_d   = seq_ok;
    assign force_q = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
            clr_q   <= 1'b0;
            kerr_q  <= 1'b0;
            eerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            clr_q   <= clr_d;
            kerr_q  <= kerr_d;
            eerr_q  <= eerr_d;
        end
    end

    // Window reads 0 during the cycle the clear pulse is high.
    wdt_sat_counter #(.WIDTH(CNT_W)) u_win_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (clr_d),
        .i_inc (1'b1),
        .o_cnt (win_cnt)
    );

    wdt_sat_counter #(.WIDTH(CNT_W)) u_kick_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (1'b0),
        .i_inc (clr_d),
        .o_cnt (o_kick_cnt)
    );

    assign o_clrwdt    = clr_q;
    assign o_key_err   = kerr_q;
    assign o_early_err = eerr_q;
    assign o_armed     = (state_q == GOT_KEY1);

endmodule

// File: tb/tb_wdt_kick_unlock.sv
// Directed self-checking bench for wdt_kick_unlock; checks {clrwdt,key_err,early_err,armed}
// one cycle after each write and the kick counter.
module tb_wdt_kick_unlock;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        clrwdt, key_err, early_err, armed;
    logic [15:0] kick_cnt;
    logic [3:0]  st;
`ifdef WDT_KICK_ERR_FORCE_EN
    logic        force_fail;
`endif

    int checks = 0;
    int errors = 0;

    wdt_kick_unlock dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_en     (wr_en),
        .i_wr_data   (wr_data),
        .o_clrwdt    (clrwdt),
        .o_key_err   (key_err),
        .o_early_err (early_err),
        .o_armed     (armed),
        .o_kick_cnt  (kick_cnt)
`ifdef WDT_KICK_ERR_FORCE_EN
        ,
        .o_force_fail(force_fail)
`endif
    );

    always #5 clk = ~clk;

    assign st = {clrwdt, key_err, early_err, armed};

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic drive(input logic en, input logic [7:0] d);
        wr_en   = en;
        wr_data = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL reset_flags_in_reset: got %b expected %b", st, 4'b0000); end
        apply_reset();
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected %b", st, 4'b0000); end
        checks++; if (kick_cnt !== 16'd0) begin errors++; $display("FAIL reset_kick_cnt: got %0d expected %0d", kick_cnt, 0); end
    endtask

    task automatic test_clear_then_early();
        apply_reset();
        idle(10);
        drive(1'b1, 8'h55);
        checks++; if (st !== 4'b0001) begin errors++; $display("FAIL clr_arm: got %b expected %b", st, 4'b0001); end
        drive(1'b1, 8'hAA);
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL clr_pulse: got %b expected %b", st, 4'b1000); end
        checks++; if (kick_cnt !== 16'd1) begin errors++; $display("FAIL clr_kick_cnt: got %0d expected %0d", kick_cnt, 1); end
        drive(1'b0, 8'h00);
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL clr_pulse_width: got %b expected %b", st, 4'b0000); end
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hAA);
        checks++; if (st !== 4'b0010) begin errors++; $display("FAIL early_pulse: got %b expected %b", st, 4'b0010); end
        checks++; if (kick_cnt !== 16'd1) begin errors++; $display("FAIL early_kick_cnt: got %0d expected %0d", kick_cnt, 1); end
        drive(1'b0, 8'h00);
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL early_pulse_width: got %b expected %b", st, 4'b0000); end
    endtask

    task automatic test_gap();
        apply_reset();
        idle(6);
        drive(1'b1, 8'h55);
        idle(7);
        checks++; if (st !== 4'b0001) begin errors++; $display("FAIL gap_still_armed: got %b expected %b", st, 4'b0001); end
        drive(1'b1, 8'hAA);
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL gap_edge_clear: got %b expected %b", st, 4'b1000); end
        checks++; if (kick_cnt !== 16'd1) begin errors++; $display("FAIL gap_edge_kick_cnt: got %0d expected %0d", kick_cnt, 1); end
        drive(1'b0, 8'h00);
        drive(1'b1, 8'h55);
        idle(7);
        checks++; if (st !== 4'b0001) begin errors++; $display("FAIL gap_pre_timeout: got %b expected %b", st, 4'b0001); end
        drive(1'b0, 8'h00);
        checks++; if (st !== 4'b0100) begin errors++; $display("FAIL gap_timeout: got %b expected %b", st, 4'b0100); end
        drive(1'b0, 8'h00);
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL gap_timeout_width: got %b expected %b", st, 4'b0000); end
        drive(1'b1, 8'hAA);
        checks++; if (st !== 4'b0100) begin errors++; $display("FAIL gap_lone_key2: got %b expected %b", st, 4'b0100); end
        drive(1'b0, 8'h00);
        checks++; if (kick_cnt !== 16'd1) begin errors++; $display("FAIL gap_kick_cnt: got %0d expected %0d", kick_cnt, 1); end
    endtask

    task automatic test_bad_sequence();
        apply_reset();
        idle(5);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h55);
        checks++; if (st !== 4'b0100) begin errors++; $display("FAIL bad_repeat_key1: got %b expected %b", st, 4'b0100); end
        drive(1'b1, 8'hAA);
        checks++; if (st !== 4'b0100) begin errors++; $display("FAIL bad_key2_in_idle: got %b expected %b", st, 4'b0100); end
        drive(1'b0, 8'h55);
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL bad_data_no_strobe: got %b expected %b", st, 4'b0000); end
        drive(1'b0, 8'hAA);
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL bad_quiet: got %b expected %b", st, 4'b0000); end
        checks++; if (kick_cnt !== 16'd0) begin errors++; $display("FAIL bad_kick_cnt: got %0d expected %0d", kick_cnt, 0); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        idle(5);
        drive(1'b1, 8'h55);
        rst   = 1'b1;
        wr_en = 1'b0;
        #1;
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL mid_reset_disarm: got %b expected %b", st, 4'b0000); end
        idle(2);
        rst = 1'b0;
        drive(1'b0, 8'h00);
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL mid_reset_release: got %b expected %b", st, 4'b0000); end
        idle(4);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hAA);
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL mid_reset_clear: got %b expected %b", st, 4'b1000); end
        checks++; if (kick_cnt !== 16'd1) begin errors++; $display("FAIL mid_reset_kick_cnt: got %0d expected %0d", kick_cnt, 1); end
    endtask

    // Continues from the clear issued at the end of test_reset_mid.
    task automatic test_window_edge();
        idle(3);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hAA);
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL win_eq_min_clear: got %b expected %b", st, 4'b1000); end
        checks++; if (kick_cnt !== 16'd2) begin errors++; $display("FAIL win_eq_min_kick_cnt: got %0d expected %0d", kick_cnt, 2); end
        idle(2);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hAA);
        checks++; if (st !== 4'b0010) begin errors++; $display("FAIL win_below_min_early: got %b expected %b", st, 4'b0010); end
        checks++; if (kick_cnt !== 16'd2) begin errors++; $display("FAIL win_below_min_kick_cnt: got %0d expected %0d", kick_cnt, 2); end
    endtask

`ifdef WDT_KICK_ERR_FORCE_EN
    task automatic test_force_fail();
        apply_reset();
        checks++; if (force_fail !== 1'b0) begin errors++; $display("FAIL force_reset: got %b expected %b", force_fail, 1'b0); end
        idle(5);
        drive(1'b1, 8'h12);
        checks++; if (st !== 4'b0100) begin errors++; $display("FAIL force_bad_byte: got %b expected %b", st, 4'b0100); end
        checks++; if (force_fail !== 1'b1) begin errors++; $display("FAIL force_set: got %b expected %b", force_fail, 1'b1); end
        idle(2);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hAA);
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL force_suppress: got %b expected %b", st, 4'b0000); end
        checks++; if (kick_cnt !== 16'd0) begin errors++; $display("FAIL force_kick_frozen: got %0d expected %0d", kick_cnt, 0); end
        idle(3);
        checks++; if (force_fail !== 1'b1) begin errors++; $display("FAIL force_held: got %b expected %b", force_fail, 1'b1); end
        apply_reset();
        checks++; if (force_fail !== 1'b0) begin errors++; $display("FAIL force_cleared: got %b expected %b", force_fail, 1'b0); end
    endtask
`else
    task automatic test_error_then_clear();
        apply_reset();
        idle(5);
        drive(1'b1, 8'h12);
        checks++; if (st !== 4'b0100) begin errors++; $display("FAIL err_bad_byte: got %b expected %b", st, 4'b0100); end
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hAA);
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL err_then_clear: got %b expected %b", st, 4'b1000); end
        checks++; if (kick_cnt !== 16'd1) begin errors++; $display("FAIL err_then_kick_cnt: got %0d expected %0d", kick_cnt, 1); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clear_then_early();
        test_gap();
        test_bad_sequence();
        test_reset_mid();
        test_window_edge();
`ifdef WDT_KICK_ERR_FORCE_EN
        test_force_fail();
`else
        test_error_then_clear();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
